dmem_arbiter: RTL and testbench

Shares the single synchronous data-memory port between the core's memory-access stage and a DMA/debug loader requester. The core has priority. A starvation counter and a bounded DMA burst mode guarantee loader progress. The block forwards the existing access-size write code to memory, rejects misaligned accesses, and returns a registered completion pulse with read data to the requester that owned each access. It sits between the memory-access stage / loader and the data RAM.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data-memory port between the core
// (priority requester) and a DMA/debug loader. A starvation counter forces a
// DMA grant after STARVE_LIMIT denied cycles, then a bounded burst lets the
// loader make progress. Misaligned accesses are granted but dropped, and
// every grant gets a registered completion pulse one cycle later.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int BURST_MAX    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c_req,
   input  logic [1:0]  c_wr,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   output logic        c_gnt,
   output logic        c_rvalid,
   output logic        c_err,
   output logic [31:0] c_rdata,
   input  logic        d_req,
   input  logic [1:0]  d_wr,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic [1:0]  mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int WW = $clog2(STARVE_LIMIT + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);
   localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_MAX);

   typedef enum logic {
      CORE_PRI  = 1'b0,
      DMA_BURST = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic [BW-1:0] beat_cnt, beat_nxt, beat_inc;
   logic          core_win, dma_win, any_gnt;
   logic [1:0]    sel_wr;
   logic [31:0]   sel_addr;
   logic          sel_misaligned;

   // Owner tag of the access granted last cycle; owner 1 means DMA.
   logic tag_valid, tag_owner, tag_err;

   // Reads fetch the whole word, so they share the word-alignment rule.
   function automatic logic is_misaligned(input logic [1:0] wr, input logic [1:0] lo);
      case (wr)
         2'd1:    return 1'b0;
         2'd2:    return lo[0];
         default: return |lo;
      endcase
   endfunction

   assign beat_inc = beat_cnt + 1'b1;

   // Winner selection and state/burst bookkeeping for the current cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
      core_win  = 1'b0;
      dma_win   = 1'b0;
      state_nxt = state;
      beat_nxt  = beat_cnt;
      case (state)
         CORE_PRI: begin
            if (c_req && (wait_cnt < WAIT_MAX)) begin
               core_win = 1'b1;
            end else if (d_req) begin
               dma_win = 1'b1;
               // Starvation override: keep the loader going for a bounded burst.
               if (c_req && (BURST_MAX > 1)) begin
                  state_nxt = DMA_BURST;
                  beat_nxt  = BW'(1);
               end
            end
         end
         DMA_BURST: begin
            if (d_req) begin
               dma_win = 1'b1;
               if (beat_inc == BEAT_MAX) begin
                  state_nxt = CORE_PRI;
                  beat_nxt  = '0;
               end else begin
                  beat_nxt = beat_inc;
               end
            end else begin
               core_win  = c_req;
               state_nxt = CORE_PRI;
               beat_nxt  = '0;
            end
         end
         default: begin
            state_nxt = CORE_PRI;
            beat_nxt  = '0;
         end
      endcase
   end

   // Grant, alignment check and memory port mux; grants are held off during reset.
   always_comb begin
      sel_wr         = dma_win ? d_wr   : c_wr;
      sel_addr       = dma_win ? d_addr : c_addr;
      mem_addr       = sel_addr;
      mem_wdata      = dma_win ? d_wdata : c_wdata;
      sel_misaligned = is_misaligned(sel_wr, sel_addr[1:0]);
      c_gnt          = core_win & rst_n;
      d_gnt          = dma_win & rst_n;
      any_gnt        = c_gnt | d_gnt;
      mem_en         = any_gnt & ~sel_misaligned;
      mem_wr         = mem_en ? sel_wr : 2'd0;
   end

   // Starvation counter: counts denied DMA request cycles, saturating.
   always_comb begin
      wait_nxt = wait_cnt;
      if (d_gnt) begin
         wait_nxt = '0;
      end else if (d_req && (wait_cnt < WAIT_MAX)) begin
         wait_nxt = wait_cnt + 1'b1;
      end
   end

   // State, counters and completion owner tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CORE_PRI;
         wait_cnt  <= '0;
         beat_cnt  <= '0;
         tag_valid <= 1'b0;
         tag_owner <= 1'b0;
         tag_err   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state     <= state_nxt;
         wait_cnt  <= wait_nxt;
         beat_cnt  <= beat_nxt;
         tag_valid <= any_gnt;
         tag_owner <= dma_win;
         tag_err   <= any_gnt & sel_misaligned;
      end
   end

   assign c_rvalid = tag_valid & ~tag_owner;
   assign d_rvalid = tag_valid &  tag_owner;
   assign c_err    = c_rvalid & tag_err;
   assign d_err    = d_rvalid & tag_err;
   assign c_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// requester traffic, compared cycle by cycle against a behavioural model of
// the arbitration rules and a bench-side memory.
module tb_dmem_arbiter;

   localparam int SL = 4;
   localparam int BM = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c_req, d_req;
   logic [1:0]  c_wr, d_wr;
   logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
   logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
   logic [31:0] c_rdata, d_rdata;
   logic        mem_en;
   logic [1:0]  mem_wr;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state.
   bit m_burst;
   int m_wait, m_beats;
   // Expected completion for the grant made in the previous cycle.
   bit          prev_v, prev_dma, prev_err, prev_rd;
   logic [31:0] prev_addr;
   // Observations of the last run cycle, for directed checks.
   logic        obs_c_gnt, obs_d_gnt, obs_mem_en;
   logic [1:0]  obs_mem_wr;
   logic [31:0] obs_mem_addr, obs_mem_wdata;
   bit          last_cw, last_dw;
   // Random requester pending flags.
   bit c_pend, d_pend;

   dmem_arbiter #(.STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_err(c_err), .c_rdata(c_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Bench memory: synchronous read data one cycle after a read strobe.
   always @(posedge clk) begin
      if (mem_en && mem_wr == 2'd0) mem_rdata <= rd_fn(mem_addr);
      else                          mem_rdata <= 32'hBAD00000;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   function automatic bit aligned_ok(input logic [1:0] wr, input logic [31:0] a);
      if (wr == 2'd1) return 1'b1;
      if (wr == 2'd2) return (a % 2) == 0;
      return (a % 4) == 0;
   endfunction

   function automatic void m_reset();
      m_burst = 1'b0;
      m_wait  = 0;
      m_beats = 0;
      prev_v  = 1'b0;
   endfunction

   // One clock cycle: entered at posedge+1 with inputs driven, left at next posedge+1.
   task automatic run_cycle();
      bit cw, dw, gnt, err;
      logic [1:0]  wr;
      logic [31:0] a, wd;
      #3;
      if (!m_burst) begin
         cw = c_req && (m_wait < SL);
         dw = !cw && d_req;
      end else begin
         dw = d_req;
         cw = c_req && !d_req;
      end
      gnt = cw || dw;
      wr  = dw ? d_wr : c_wr;
      a   = dw ? d_addr : c_addr;
      wd  = dw ? d_wdata : c_wdata;
      err = gnt && !aligned_ok(wr, a);

      obs_c_gnt = c_gnt; obs_d_gnt = d_gnt; obs_mem_en = mem_en;
      obs_mem_wr = mem_wr; obs_mem_addr = mem_addr; obs_mem_wdata = mem_wdata;

      check("c_gnt", 32'(c_gnt), 32'(cw));
      check("d_gnt", 32'(d_gnt), 32'(dw));
      check("mem_en", 32'(mem_en), 32'(gnt && !err));
      check("mem_wr", 32'(mem_wr), (gnt && !err) ? 32'(wr) : 32'd0);
      if (gnt && !err) begin
         check("mem_addr", mem_addr, a);
         check("mem_wdata", mem_wdata, wd);
      end
      check("c_rvalid", 32'(c_rvalid), 32'(prev_v && !prev_dma));
      check("d_rvalid", 32'(d_rvalid), 32'(prev_v && prev_dma));
      check("c_err", 32'(c_err), 32'(prev_v && !prev_dma && prev_err));
      check("d_err", 32'(d_err), 32'(prev_v && prev_dma && prev_err));
      if (prev_v && prev_rd && !prev_err) begin
         if (prev_dma) check("d_rdata", d_rdata, rd_fn(prev_addr));
         else          check("c_rdata", c_rdata, rd_fn(prev_addr));
      end

      prev_v = gnt; prev_dma = dw; prev_err = err;
      prev_rd = (wr == 2'd0); prev_addr = a;

      if (dw) m_wait = 0;
      else if (d_req && m_wait < SL) m_wait = m_wait + 1;
      if (!m_burst) begin
         if (dw && c_req && BM > 1) begin
            m_burst = 1'b1;
            m_beats = 1;
         end
      end else if (dw) begin
         m_beats = m_beats + 1;
         if (m_beats == BM) begin
            m_burst = 1'b0;
            m_beats = 0;
         end
      end else begin
         m_burst = 1'b0;
         m_beats = 0;
      end
      last_cw = cw;
      last_dw = dw;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_core(input logic req, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] wd);
      c_req = req; c_wr = wr; c_addr = a; c_wdata = wd;
   endtask

   task automatic drive_dma(input logic req, input logic [1:0] wr, input logic [31:0] a, input logic [31:0] wd);
      d_req = req; d_wr = wr; d_addr = a; d_wdata = wd;
   endtask

   // Reset asserted at posedge+1, held two edges, released away from an edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      check("rst_c_gnt", 32'(c_gnt), 32'd0);
      check("rst_d_gnt", 32'(d_gnt), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_c_rvalid", 32'(c_rvalid), 32'd0);
      check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      m_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      c_pend = 1'b0;
      d_pend = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      drive_core(1'b1, 2'd0, 32'h0, 32'h0);
      drive_dma(1'b1, 2'd0, 32'h4, 32'h0);
      @(posedge clk); #1;
      do_reset();

      // Core-only read.
      drive_dma(1'b0, 2'd0, 32'h0, 32'h0);
      drive_core(1'b1, 2'd0, 32'h100, 32'h0);
      run_cycle();
      check("t1_gnt", 32'(obs_c_gnt), 32'd1);
      check("t1_addr", obs_mem_addr, 32'h100);
      check("t1_wr", 32'(obs_mem_wr), 32'd0);
      drive_core(1'b0, 2'd0, 32'h0, 32'h0);
      check("t1_rvalid", 32'(c_rvalid), 32'd1);
      check("t1_rdata", c_rdata, 32'hDEADBEEF);
      check("t1_d_rvalid", 32'(d_rvalid), 32'd0);
      run_cycle();

      // Sustained contention: 4 core grants then 4 DMA grants, repeating.
      do_reset();
      drive_core(1'b1, 2'd0, 32'h300, 32'h0);
      drive_dma(1'b1, 2'd0, 32'h400, 32'h0);
      for (int i = 0; i < 24; i++) begin
         run_cycle();
         check("t2_pattern", 32'(obs_d_gnt), 32'((i % 8) >= 4));
      end

      // Burst early exit after two DMA beats.
      do_reset();
      drive_core(1'b1, 2'd3, 32'h500, 32'h11);
      drive_dma(1'b1, 2'd3, 32'h600, 32'h22);
      for (int i = 0; i < 6; i++) run_cycle();
      d_req = 1'b0;
      run_cycle();
      check("t3_exit_core", 32'(obs_c_gnt), 32'd1);
      d_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_cycle();
         check("t3_core_pri", 32'(obs_c_gnt), 32'd1);
      end

      // Misaligned word write, then an always-aligned byte write.
      do_reset();
      drive_dma(1'b0, 2'd0, 32'h0, 32'h0);
      drive_core(1'b1, 2'd3, 32'h102, 32'h12345678);
      run_cycle();
      check("t4_gnt", 32'(obs_c_gnt), 32'd1);
      check("t4_mem_en", 32'(obs_mem_en), 32'd0);
      check("t4_rvalid", 32'(c_rvalid), 32'd1);
      check("t4_err", 32'(c_err), 32'd1);
      drive_core(1'b1, 2'd1, 32'h103, 32'h000000AB);
      run_cycle();
      check("t4_byte_en", 32'(obs_mem_en), 32'd1);
      check("t4_byte_wr", 32'(obs_mem_wr), 32'd1);

      // DMA half write with no core request.
      drive_core(1'b0, 2'd0, 32'h0, 32'h0);
      drive_dma(1'b1, 2'd2, 32'h200, 32'h0000ABCD);
      run_cycle();
      check("t5_gnt", 32'(obs_d_gnt), 32'd1);
      check("t5_wr", 32'(obs_mem_wr), 32'd2);
      check("t5_wdata", obs_mem_wdata, 32'h0000ABCD);
      check("t5_rvalid", 32'(d_rvalid), 32'd1);
      check("t5_err", 32'(d_err), 32'd0);

      // Reset in the cycle after a DMA read grant.
      drive_dma(1'b1, 2'd0, 32'h240, 32'h0);
      run_cycle();
      check("t6_dma_gnt", 32'(obs_d_gnt), 32'd1);
      drive_dma(1'b1, 2'd0, 32'h244, 32'h0);
      drive_core(1'b1, 2'd0, 32'h248, 32'h0);
      do_reset();
      run_cycle();
      check("t6_core_first", 32'(obs_c_gnt), 32'd1);

      // Randomized traffic: each requester holds its access until granted.
      drive_core(1'b0, 2'd0, 32'h0, 32'h0);
      drive_dma(1'b0, 2'd0, 32'h0, 32'h0);
      c_pend = 1'b0;
      d_pend = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!c_pend && ($urandom_range(0, 3) != 0)) begin
            c_pend = 1'b1;
            drive_core(1'b1, 2'($urandom_range(0, 3)), $urandom & 32'h3FF, $urandom);
         end
         if (!d_pend && ($urandom_range(0, 2) != 0)) begin
            d_pend = 1'b1;
            drive_dma(1'b1, 2'($urandom_range(0, 3)), ($urandom & 32'h3FF) | 32'h400, $urandom);
         end
         c_req = c_pend;
         d_req = d_pend;
         run_cycle();
         if (last_cw) c_pend = 1'b0;
         if (last_dw) d_pend = 1'b0;
         c_req = c_pend;
         d_req = d_pend;
      end
      drive_core(1'b0, 2'd0, 32'h0, 32'h0);
      drive_dma(1'b0, 2'd0, 32'h0, 32'h0);
      run_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
